fetch_stage: RTL and testbench

- Instruction-fetch front end, directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues requests to a fixed 1-cycle-latency instruction memory.
- Buffers returned words with their PCs in a small FIFO and presents one {PC, PC+4, instr, valid} per cycle to IF/ID.
- Handles stall from the hazard unit and branch/jump redirect from EX, discarding wrong-path words.

---
 rtl/rv32_pkg.sv | 9 +
 rtl/fetch_fifo.sv | 37 +++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 constants and the fetch buffer entry type
package rv32_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous buffer of fetched {pc, instr} entries with flush
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  fetch_entry_t           din_i,
  output fetch_entry_t           head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   count_q;
  // flush beats push so a redirect never keeps a wrong-path word
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) rd_q <= rd_q + AW'(1);
      count_q <= count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: fetch PC, 1-cycle imem requests, entry buffer, stall/redirect; FETCH_MISALIGN_CHECK_EN traps misaligned redirects
module fetch_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] instr_out,
  output logic        valid_out
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_misaligned
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [31:0]   fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic          inflight_q, inflight_d, drop_q, drop_d;
  logic          push, pop, fifo_pop, fifo_valid, space;
  logic [CW-1:0] count;
  logic [CW:0]   occ;
  fetch_entry_t  head, din;
  logic          mis_q, halt_q;
  logic [31:0]   mis_pc_q;

  assign din = '{pc: req_pc_q, instr: imem_rdata};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .pop_i  (fifo_pop),
    .flush_i(redirect),
    .din_i  (din),
    .head_o (head),
    .count_o(count)
  );

  // request only when the word it returns is sure to find a free slot
  always_comb begin
    fifo_valid = count != '0;
    valid_out  = fifo_valid || mis_q;
    pop        = valid_out && !stall && !redirect;
    fifo_pop   = pop && fifo_valid;
    push       = imem_rvalid && inflight_q && !drop_q;
    occ        = {1'b0, count} - (CW+1)'(fifo_pop) + (CW+1)'(inflight_q);
    space      = occ < (CW+1)'(FIFO_DEPTH);
    imem_req   = !rst && !redirect && space && !halt_q;
    imem_addr  = fetch_pc_q;
    fetch_pc_d = redirect ? (redirect_pc & 32'hFFFF_FFFC) : imem_req ? fetch_pc_q + 32'd4 : fetch_pc_q;
    req_pc_d   = imem_req ? fetch_pc_q : req_pc_q;
    inflight_d = imem_req || (inflight_q && !imem_rvalid);
    drop_d     = redirect ? (inflight_q && !imem_rvalid) : (drop_q && !imem_rvalid);
    pc_out     = mis_q ? mis_pc_q : fifo_valid ? head.pc : 32'd0;
    pc4_out    = valid_out ? pc_out + 32'd4 : 32'd0;
    instr_out  = fifo_valid ? head.instr : NOP_INSTR;
  end

  // fetch PC, outstanding-request tracking and wrong-path drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  // a misaligned target yields one NOP trap entry and halts fetch until the next redirect
  always_ff @(posedge clk) begin
    if (rst) begin
      mis_q    <= 1'b0;
      halt_q   <= 1'b0;
      mis_pc_q <= '0;
    end else if (redirect) begin
      mis_q    <= |redirect_pc[1:0];
      halt_q   <= |redirect_pc[1:0];
      mis_pc_q <= redirect_pc;
    end else if (pop) begin
      mis_q    <= 1'b0;
    end
  end
  assign fetch_misaligned = mis_q;
`else
  assign mis_q    = 1'b0;
  assign halt_q   = 1'b0;
  assign mis_pc_q = '0;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect against a program-order model
module tb_fetch_stage;
  localparam logic [31:0] RPC = 32'h100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, valid_out;
  logic [31:0] imem_addr, pc_out, pc4_out, instr_out;
  logic [31:0] imem_rdata = '0;
  logic imem_rvalid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic fetch_misaligned;
`endif
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
    .pc_out(pc_out), .pc4_out(pc4_out), .instr_out(instr_out), .valid_out(valid_out)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  function automatic logic [31:0] memw(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_2468;
  endfunction

  always @(posedge clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= memw(imem_addr);
  end

  task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
    @(negedge clk);
    rst = r; stall = s; redirect = d; redirect_pc = t;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 0);
      n_cmp++; if ({valid_out, imem_req} !== 2'b00) begin n_bad++; $display("FAIL reset_valid_req got %b want 00", {valid_out, imem_req}); end
      n_cmp++; if (pc_out !== 0 || pc4_out !== 0) begin n_bad++; $display("FAIL reset_pc got %h/%h want 0/0", pc_out, pc4_out); end
      n_cmp++; if (instr_out !== NOP) begin n_bad++; $display("FAIL reset_instr got %h want %h", instr_out, NOP); end
    end
  endtask

  task automatic test_startup();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RPC + 4 * i) begin n_bad++; $display("FAIL start_req%0d got %b/%h want 1/%h", i, imem_req, imem_addr, RPC + 4 * i); end
      n_cmp++; if (valid_out !== (i >= 2)) begin n_bad++; $display("FAIL start_valid%0d got %b want %b", i, valid_out, i >= 2); end
      if (i >= 2) begin
        n_cmp++; if (pc_out !== RPC || pc4_out !== RPC + 4 || instr_out !== memw(RPC)) begin n_bad++; $display("FAIL start_head got %h/%h/%h want %h/%h/%h", pc_out, pc4_out, instr_out, RPC, RPC + 4, memw(RPC)); end
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 0);
      n_cmp++; if (valid_out !== 1'b1 || pc_out !== RPC + 4 || instr_out !== memw(RPC + 4)) begin n_bad++; $display("FAIL stall_head%0d got %b/%h want 1/%h", i, valid_out, pc_out, RPC + 4); end
      n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_req%0d got %b want 0", i, imem_req); end
    end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== RPC + 4) begin n_bad++; $display("FAIL stall_release got %b/%h want 1/%h", valid_out, pc_out, RPC + 4); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RPC + 12) begin n_bad++; $display("FAIL stall_resume_req got %b/%h want 1/%h", imem_req, imem_addr, RPC + 12); end
  endtask

  task automatic test_redirect();
    drive(0, 0, 1, 32'h200);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== RPC + 8) begin n_bad++; $display("FAIL redir_head got %b/%h want 1/%h", valid_out, pc_out, RPC + 8); end
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL redir_req got %b want 0", imem_req); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL redir_flush%0d got %b want 0", i, valid_out); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 + 4 * i) begin n_bad++; $display("FAIL redir_target%0d got %b/%h want 1/%h", i, imem_req, imem_addr, 32'h200 + 4 * i); end
    end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== memw(32'h200)) begin n_bad++; $display("FAIL redir_first got %b/%h/%h want 1/200/%h", valid_out, pc_out, instr_out, memw(32'h200)); end
  endtask

  task automatic test_redirect_stall();
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h204) begin n_bad++; $display("FAIL rs_full_head got %b/%h want 1/204", valid_out, pc_out); end
    drive(0, 1, 1, 32'h400);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rs_req got %b want 0", imem_req); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 0, 0);
      n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL rs_flush%0d got %b want 0", i, valid_out); end
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h400 + 4 * i) begin n_bad++; $display("FAIL rs_target%0d got %b/%h want 1/%h", i, imem_req, imem_addr, 32'h400 + 4 * i); end
    end
    drive(0, 1, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h400) begin n_bad++; $display("FAIL rs_held got %b/%h want 1/400", valid_out, pc_out); end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0);
      n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h400 + 4 * i || instr_out !== memw(32'h400 + 4 * i)) begin n_bad++; $display("FAIL rs_seq%0d got %b/%h want 1/%h", i, valid_out, pc_out, 32'h400 + 4 * i); end
    end
  endtask

  task automatic test_reset_midstream();
    drive(0, 0, 0, 0);
    drive(1, 0, 0, 0);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mrst_req got %b want 0", imem_req); end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b0 || pc_out !== 0 || pc4_out !== 0 || instr_out !== NOP) begin n_bad++; $display("FAIL mrst_out got %b/%h/%h/%h want 0/0/0/%h", valid_out, pc_out, pc4_out, instr_out, NOP); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RPC) begin n_bad++; $display("FAIL mrst_restart got %b/%h want 1/%h", imem_req, imem_addr, RPC); end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b0) begin n_bad++; $display("FAIL mrst_stale got %b want 0", valid_out); end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== RPC || instr_out !== memw(RPC)) begin n_bad++; $display("FAIL mrst_first got %b/%h want 1/%h", valid_out, pc_out, RPC); end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = '0, exp_req = '0, t;
    logic s, d;
    int since = 0, outst = 0;
    for (int i = 0; i < 1500; i++) begin
      d = (i == 0) || ($urandom_range(0, 15) == 0);
      s = $urandom_range(0, 2) == 0;
      t = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      t = t & 32'hFFFF_FFFC;
`endif
      drive(0, s, d, t);
      if (d) begin
        n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL rnd_redir_req c%0d got %b want 0", i, imem_req); end
      end
      if (i > 0) begin
        n_cmp++; if (valid_out !== (since >= 2)) begin n_bad++; $display("FAIL rnd_valid c%0d got %b want %b", i, valid_out, since >= 2); end
        if (!valid_out) begin
          n_cmp++; if (pc_out !== 0 || pc4_out !== 0 || instr_out !== NOP) begin n_bad++; $display("FAIL rnd_idle c%0d got %h/%h/%h", i, pc_out, pc4_out, instr_out); end
        end
        if (imem_req) begin
          n_cmp++; if (imem_addr !== exp_req) begin n_bad++; $display("FAIL rnd_addr c%0d got %h want %h", i, imem_addr, exp_req); end
          exp_req += 4; outst++;
        end
        if (valid_out && !s && !d) begin
          n_cmp++; if (pc_out !== exp_pc || pc4_out !== exp_pc + 4 || instr_out !== memw(exp_pc)) begin n_bad++; $display("FAIL rnd_pop c%0d got %h/%h/%h want %h/%h/%h", i, pc_out, pc4_out, instr_out, exp_pc, exp_pc + 4, memw(exp_pc)); end
          exp_pc += 4; outst--;
        end
        n_cmp++; if (outst > 2) begin n_bad++; $display("FAIL rnd_outstanding c%0d got %0d want <=2", i, outst); end
      end
      if (d) begin
        exp_pc = t & 32'hFFFF_FFFC; exp_req = exp_pc; outst = 0; since = 0;
      end else since++;
    end
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    drive(0, 0, 1, 32'h202);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_redir_req got %b want 0", imem_req); end
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h202 || pc4_out !== 32'h206 || instr_out !== NOP) begin n_bad++; $display("FAIL mis_entry got %b/%h/%h/%h want 1/202/206/%h", valid_out, pc_out, pc4_out, instr_out, NOP); end
    n_cmp++; if (fetch_misaligned !== 1'b1 || imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_flag got %b/%b want 1/0", fetch_misaligned, imem_req); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      n_cmp++; if ({valid_out, fetch_misaligned, imem_req} !== 3'b000) begin n_bad++; $display("FAIL mis_halt%0d got %b want 000", i, {valid_out, fetch_misaligned, imem_req}); end
    end
    drive(0, 0, 1, 32'h300);
    drive(0, 0, 0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h300 || fetch_misaligned !== 1'b0) begin n_bad++; $display("FAIL mis_resume got %b/%h want 1/300", imem_req, imem_addr); end
  endtask
`else
  task automatic test_misalign();
    drive(0, 0, 1, 32'h202);
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL mis_redir_req got %b want 0", imem_req); end
    drive(0, 0, 0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_bad++; $display("FAIL mis_forced got %b/%h want 1/200", imem_req, imem_addr); end
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    n_cmp++; if (valid_out !== 1'b1 || pc_out !== 32'h200 || instr_out !== memw(32'h200)) begin n_bad++; $display("FAIL mis_first got %b/%h want 1/200", valid_out, pc_out); end
  endtask
`endif

  initial begin
    test_reset();
    test_startup();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_midstream();
    test_random();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
